// File: rtl/controle_multiciclo.sv
// Multicycle control FSM: fetch/decode/execute/memory/write-back sequencing for the 4-bit-opcode core.
// Optional retired-instruction counter enabled by defining CONT_INSTR_EN.
module controle_multiciclo #(
    parameter int LARGURA_CONT = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              opcode,
    input  logic                    mem_pronto,
    output logic                    EscCondCP,
    output logic                    CondInv,
    output logic                    EscCP,
    output logic                    EscIR,
    output logic                    IouD,
    output logic                    LeMem,
    output logic                    EscMem,
    output logic                    MemParaReg,
    output logic                    RegDst,
    output logic                    EscReg,
    output logic                    ULA_A,
    output logic [1:0]              ULA_B,
    output logic [2:0]              ULA_OP,
    output logic [1:0]              FonteCP,
    output logic [3:0]              estado,
    output logic                    parado
`ifdef CONT_INSTR_EN
    ,
    output logic [LARGURA_CONT-1:0] cont_instr
`endif
);

    typedef enum logic [3:0] {
        OCIOSO      = 4'd0,
        BUSCA       = 4'd1,
        DECOD       = 4'd2,
        EXEC_R      = 4'd3,
        EXEC_I      = 4'd4,
        ESC_ULA     = 4'd5,
        END_MEM     = 4'd6,
        LE_MEM      = 4'd7,
        ESC_REG_MEM = 4'd8,
        ESC_MEM     = 4'd9,
        DESVIO      = 4'd10,
        SALTO       = 4'd11,
        PARADO      = 4'd12
    } estado_t;

    estado_t state, next;

    if (LARGURA_CONT < 1) begin : g_largura_invalida
        $error("LARGURA_CONT must be at least 1");
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= OCIOSO;
        else     state <= next;
    end

    assign estado = state;

    // Outputs decode only the state register, so an async reset drops the
    // memory strobes without waiting for a clock edge.
    always_comb begin
        next       = BUSCA;
        EscCondCP  = 1'b0;
        CondInv    = 1'b0;
        EscCP      = 1'b0;
        EscIR      = 1'b0;
        IouD       = 1'b0;
        LeMem      = 1'b0;
        EscMem     = 1'b0;
        MemParaReg = 1'b0;
        RegDst     = 1'b0;
        EscReg     = 1'b0;
        ULA_A      = 1'b0;
        ULA_B      = 2'b00;
        ULA_OP     = 3'b000;
        FonteCP    = 2'b00;
        parado     = 1'b0;

        case (state)
            OCIOSO: next = BUSCA;

            BUSCA: begin
                LeMem = 1'b1;
                ULA_B = 2'b01;
                EscIR = mem_pronto;
                EscCP = mem_pronto;
                next  = mem_pronto ? DECOD : BUSCA;
            end

            DECOD: begin
                ULA_B = 2'b10;
                if (!opcode[3]) begin
                    next = EXEC_R;
                end else begin
                    case (opcode[2:0])
                        3'b000:  next = EXEC_I;
                        3'b001,
                        3'b010:  next = END_MEM;
                        3'b011:  next = SALTO;
                        3'b100,
                        3'b101:  next = DESVIO;
                        3'b110:  next = BUSCA;
                        default: next = PARADO;
                    endcase
                end
            end

            EXEC_R: begin
                ULA_A  = 1'b1;
                ULA_OP = opcode[2:0];
                next   = ESC_ULA;
            end

            EXEC_I: begin
                ULA_A = 1'b1;
                ULA_B = 2'b10;
                next  = ESC_ULA;
            end

            ESC_ULA: begin
                EscReg = 1'b1;
                RegDst = ~opcode[3];
                next   = BUSCA;
            end

            END_MEM: begin
                ULA_A = 1'b1;
                ULA_B = 2'b10;
                next  = (opcode == 4'b1010) ? ESC_MEM : LE_MEM;
            end

            LE_MEM: begin
                LeMem = 1'b1;
                IouD  = 1'b1;
                next  = mem_pronto ? ESC_REG_MEM : LE_MEM;
            end

            ESC_REG_MEM: begin
                EscReg     = 1'b1;
                MemParaReg = 1'b1;
                next       = BUSCA;
            end

            ESC_MEM: begin
                EscMem = 1'b1;
                IouD   = 1'b1;
                next   = mem_pronto ? BUSCA : ESC_MEM;
            end

            DESVIO: begin
                ULA_A     = 1'b1;
                ULA_OP    = 3'b001;
                EscCondCP = 1'b1;
                FonteCP   = 2'b01;
                CondInv   = (opcode == 4'b1101);
                next      = BUSCA;
            end

            SALTO: begin
                EscCP   = 1'b1;
                FonteCP = 2'b10;
                next    = BUSCA;
            end

            PARADO: begin
                parado = 1'b1;
                next   = PARADO;
            end

            default: next = BUSCA;
        endcase
    end

`ifdef CONT_INSTR_EN
    // An instruction retires on its last cycle, i.e. any return to BUSCA except
    // the start-up OCIOSO->BUSCA step and recovery from an illegal code.
    logic retira;

    always_comb begin
        retira = 1'b0;
        if (next == BUSCA) begin
            case (state)
                ESC_ULA, ESC_REG_MEM, ESC_MEM,
                DESVIO, SALTO, DECOD: retira = 1'b1;
                default:              retira = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         cont_instr <= '0;
        else if (retira) cont_instr <= cont_instr + LARGURA_CONT'(1);
    end
`endif

endmodule

// File: tb/tb_controle_multiciclo.sv
// Table-driven bench for controle_multiciclo plus hand sequences for halt, async reset and the counter.
module tb_controle_multiciclo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opcode = 4'b0000;
    logic       mem_pronto = 1'b0;
    logic       EscCondCP, CondInv, EscCP, EscIR, IouD, LeMem, EscMem;
    logic       MemParaReg, RegDst, EscReg, ULA_A, parado;
    logic [1:0] ULA_B, FonteCP;
    logic [2:0] ULA_OP;
    logic [3:0] estado;
`ifdef CONT_INSTR_EN
    logic [31:0] cont_instr;
`endif

    controle_multiciclo #(.LARGURA_CONT(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_pronto(mem_pronto),
        .EscCondCP(EscCondCP), .CondInv(CondInv), .EscCP(EscCP), .EscIR(EscIR),
        .IouD(IouD), .LeMem(LeMem), .EscMem(EscMem), .MemParaReg(MemParaReg),
        .RegDst(RegDst), .EscReg(EscReg), .ULA_A(ULA_A), .ULA_B(ULA_B),
        .ULA_OP(ULA_OP), .FonteCP(FonteCP), .estado(estado), .parado(parado)
`ifdef CONT_INSTR_EN
        , .cont_instr(cont_instr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       esc_cond_cp, cond_inv, esc_cp, esc_ir, iou_d, le_mem, esc_mem;
        logic       mem_para_reg, reg_dst, esc_reg, ula_a;
        logic [1:0] ula_b;
        logic [2:0] ula_op;
        logic [1:0] fonte_cp;
        logic       parado;
    } outs_t;

    typedef struct {
        logic [3:0] op;
        logic       mp;
        logic [3:0] est;
        outs_t      out;
    } vec_t;

    outs_t act;
    assign act = {EscCondCP, CondInv, EscCP, EscIR, IouD, LeMem, EscMem,
                  MemParaReg, RegDst, EscReg, ULA_A, ULA_B, ULA_OP, FonteCP, parado};

    localparam outs_t O_ZERO    = '0;
    localparam outs_t O_BUSCA_W = '{le_mem:1'b1, ula_b:2'b01, default:'0};
    localparam outs_t O_BUSCA_R = '{le_mem:1'b1, esc_ir:1'b1, esc_cp:1'b1, ula_b:2'b01, default:'0};
    localparam outs_t O_DECOD   = '{ula_b:2'b10, default:'0};
    localparam outs_t O_EXR_1   = '{ula_a:1'b1, ula_op:3'b001, default:'0};
    localparam outs_t O_EXR_7   = '{ula_a:1'b1, ula_op:3'b111, default:'0};
    localparam outs_t O_EXEC_I  = '{ula_a:1'b1, ula_b:2'b10, default:'0};
    localparam outs_t O_ESC_R   = '{esc_reg:1'b1, reg_dst:1'b1, default:'0};
    localparam outs_t O_ESC_I   = '{esc_reg:1'b1, default:'0};
    localparam outs_t O_END_MEM = '{ula_a:1'b1, ula_b:2'b10, default:'0};
    localparam outs_t O_LE      = '{le_mem:1'b1, iou_d:1'b1, default:'0};
    localparam outs_t O_ESC_RM  = '{esc_reg:1'b1, mem_para_reg:1'b1, default:'0};
    localparam outs_t O_ESC_MEM = '{esc_mem:1'b1, iou_d:1'b1, default:'0};
    localparam outs_t O_BEQ     = '{ula_a:1'b1, ula_op:3'b001, esc_cond_cp:1'b1, fonte_cp:2'b01, default:'0};
    localparam outs_t O_BNE     = '{ula_a:1'b1, ula_op:3'b001, esc_cond_cp:1'b1, fonte_cp:2'b01,
                                    cond_inv:1'b1, default:'0};
    localparam outs_t O_SALTO   = '{esc_cp:1'b1, fonte_cp:2'b10, default:'0};
    localparam outs_t O_PARADO  = '{parado:1'b1, default:'0};

    int n_cmp = 0;
    int n_err = 0;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] op, input logic mp, input logic [3:0] est, input outs_t o);
        vec_t v;
        v.op = op; v.mp = mp; v.est = est; v.out = o;
        tbl.push_back(v);
    endtask

    // One cycle of a hand sequence: drive at the falling edge, check state just after.
    task automatic cyc(input logic [3:0] op, input logic mp, input logic [3:0] est);
        @(negedge clk);
        opcode = op; mem_pronto = mp;
        #1 chk("seq_estado", 32'(estado), 32'(est));
    endtask

    task automatic release_rst();
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        // R-type 0001
        add(4'b0001, 1, 0,  O_ZERO);
        add(4'b0001, 1, 1,  O_BUSCA_R);
        add(4'b0001, 1, 2,  O_DECOD);
        add(4'b0001, 1, 3,  O_EXR_1);
        add(4'b0001, 1, 5,  O_ESC_R);
        // ADDI with one fetch wait; mem_pronto ignored in DECOD
        add(4'b1000, 0, 1,  O_BUSCA_W);
        add(4'b1000, 1, 1,  O_BUSCA_R);
        add(4'b1000, 0, 2,  O_DECOD);
        add(4'b1000, 0, 4,  O_EXEC_I);
        add(4'b1000, 0, 5,  O_ESC_I);
        // LW with three wait cycles in LE_MEM: 8 cycles fetch to fetch
        add(4'b1001, 1, 1,  O_BUSCA_R);
        add(4'b1001, 0, 2,  O_DECOD);
        add(4'b1001, 0, 6,  O_END_MEM);
        add(4'b1001, 0, 7,  O_LE);
        add(4'b1001, 0, 7,  O_LE);
        add(4'b1001, 0, 7,  O_LE);
        add(4'b1001, 1, 7,  O_LE);
        add(4'b1001, 0, 8,  O_ESC_RM);
        // SW with one write wait
        add(4'b1010, 1, 1,  O_BUSCA_R);
        add(4'b1010, 1, 2,  O_DECOD);
        add(4'b1010, 1, 6,  O_END_MEM);
        add(4'b1010, 0, 9,  O_ESC_MEM);
        add(4'b1010, 1, 9,  O_ESC_MEM);
        // BEQ, BNE, JUMP, NOP
        add(4'b1100, 1, 1,  O_BUSCA_R);
        add(4'b1100, 1, 2,  O_DECOD);
        add(4'b1100, 1, 10, O_BEQ);
        add(4'b1101, 1, 1,  O_BUSCA_R);
        add(4'b1101, 1, 2,  O_DECOD);
        add(4'b1101, 1, 10, O_BNE);
        add(4'b1011, 1, 1,  O_BUSCA_R);
        add(4'b1011, 1, 2,  O_DECOD);
        add(4'b1011, 1, 11, O_SALTO);
        add(4'b1110, 1, 1,  O_BUSCA_R);
        add(4'b1110, 1, 2,  O_DECOD);
        // R-type 0111 passes opcode[2:0] to the ULA
        add(4'b0111, 1, 1,  O_BUSCA_R);
        add(4'b0111, 1, 2,  O_DECOD);
        add(4'b0111, 1, 3,  O_EXR_7);
        add(4'b0111, 1, 5,  O_ESC_R);
        // HALT
        add(4'b1111, 1, 1,  O_BUSCA_R);
        add(4'b1111, 1, 2,  O_DECOD);
        add(4'b1111, 1, 12, O_PARADO);

        // Reset state while rst is held
        #2 chk("reset_estado", 32'(estado), 32'd0);
        chk("reset_outs", 32'(act), 32'(O_ZERO));
`ifdef CONT_INSTR_EN
        chk("reset_cont", cont_instr, 32'd0);
`endif
        release_rst();

        foreach (tbl[i]) begin
            @(negedge clk);
            opcode = tbl[i].op; mem_pronto = tbl[i].mp;
            #1;
            chk($sformatf("vec%0d_estado", i), 32'(estado), 32'(tbl[i].est));
            chk($sformatf("vec%0d_outs", i), 32'(act), 32'(tbl[i].out));
        end
`ifdef CONT_INSTR_EN
        chk("cont_after_table", cont_instr, 32'd9);
`endif

        // HALT is sticky for any opcode / mem_pronto
        for (int k = 0; k < 20; k++) begin
            cyc(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'd12);
            chk("halt_outs", 32'(act), 32'(O_PARADO));
        end

        // Async reset out of PARADO, checked before any clock edge
        #2 rst = 1'b1;
        #1 chk("halt_rst_estado", 32'(estado), 32'd0);
        chk("halt_rst_outs", 32'(act), 32'(O_ZERO));
        release_rst();

        // ADD, SW, NOP, HALT
        cyc(4'b0000, 1, 0); cyc(4'b0000, 1, 1); cyc(4'b0000, 1, 2);
        cyc(4'b0000, 1, 3); cyc(4'b0000, 1, 5);
        cyc(4'b1010, 1, 1); cyc(4'b1010, 1, 2); cyc(4'b1010, 1, 6); cyc(4'b1010, 1, 9);
        cyc(4'b1110, 1, 1); cyc(4'b1110, 1, 2);
`ifdef CONT_INSTR_EN
        #1 chk("cont_three", cont_instr, 32'd2);
`endif
        cyc(4'b1111, 1, 1); cyc(4'b1111, 1, 2); cyc(4'b1111, 1, 12);
`ifdef CONT_INSTR_EN
        chk("cont_halt", cont_instr, 32'd3);
`endif
        cyc(4'b1111, 1, 12);
`ifdef CONT_INSTR_EN
        chk("cont_halt_held", cont_instr, 32'd3);
`endif
        #2 rst = 1'b1;
        #1 chk("rst2_estado", 32'(estado), 32'd0);
        release_rst();

        // NOP then LW parked in LE_MEM; reset there drops LeMem at once
        cyc(4'b1110, 1, 0); cyc(4'b1110, 1, 1); cyc(4'b1110, 1, 2);
        cyc(4'b1001, 1, 1); cyc(4'b1001, 0, 2); cyc(4'b1001, 0, 6);
        cyc(4'b1001, 0, 7); cyc(4'b1001, 0, 7);
        chk("le_mem_before_rst", 32'(LeMem), 32'd1);
`ifdef CONT_INSTR_EN
        chk("cont_before_rst", cont_instr, 32'd1);
`endif
        #2 rst = 1'b1;
        #1 chk("mid_rst_lemem", 32'(LeMem), 32'd0);
        chk("mid_rst_estado", 32'(estado), 32'd0);
        chk("mid_rst_outs", 32'(act), 32'(O_ZERO));
`ifdef CONT_INSTR_EN
        chk("mid_rst_cont", cont_instr, 32'd0);
`endif
        release_rst();
        cyc(4'b1110, 0, 0);
        cyc(4'b1110, 0, 1);
        chk("after_rst_busca_outs", 32'(act), 32'(O_BUSCA_W));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
- Multicycle control FSM for the 4-bit-opcode processor datapath (PC, IR, register file, ULA, unified instruction/data memory).
- Sequences each instruction through fetch, decode, execute, memory and write-back cycles.
- Drives every datapath write-enable and mux select.
- Waits on a memory-ready handshake for every memory access.

Parameters:
- LARGURA_CONT, 32, width of the retired-instruction counter (used only with CONT_INSTR_EN).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  4  IR[15:12]; stable from the end of fetch until the next fetch.
- mem_pronto  input  1  memory has completed the current read/write this cycle.
- EscCondCP  output  1  conditional PC write (branch).
- CondInv  output  1  branch on ULA zero=0 instead of zero=1.
- EscCP  output  1  unconditional PC write.
- EscIR  output  1  IR write.
- IouD  output  1  memory address: 0=PC, 1=ULASaida.
- LeMem  output  1  memory read strobe.
- EscMem  output  1  memory write strobe.
- MemParaReg  output  1  write-back source: 0=ULASaida, 1=MDR.
- RegDst  output  1  destination register: 1=rd, 0=rt.
- EscReg  output  1  register file write.
- ULA_A  output  1  0=PC, 1=reg A.
- ULA_B  output  2  00=reg B, 01=constant 1, 10=sign-extended immediate, 11=reserved (never driven).
- ULA_OP  output  3  000 add, 001 sub, others pass opcode[2:0].
- FonteCP  output  2  00=ULA result, 01=ULASaida, 10=jump target.
- estado  output  4  current state code (debug).
- parado  output  1  core halted.
- cont_instr  output  LARGURA_CONT  retired instructions (CONT_INSTR_EN only).

Behaviour:
- Opcode map:
  - 0000-0111: R-type; ULA_OP = opcode[2:0].
  - 1000: ADDI.
  - 1001: LW.
  - 1010: SW.
  - 1011: JUMP.
  - 1100: BEQ.
  - 1101: BNE.
  - 1110: NOP.
  - 1111: HALT.
- Moore outputs decode the state register. Exception: EscIR and EscCP in BUSCA are gated by mem_pronto.
- Any output not listed for a state is 0.
- Reset (async) sets the state to OCIOSO (0). All outputs are 0, cont_instr=0, and memory strobes drop immediately, including when reset arrives mid-instruction.
- State codes and transitions:
  - OCIOSO (0): first clock after rst deasserts -> BUSCA.
  - BUSCA (1): LeMem=1, IouD=0, ULA_A=0, ULA_B=01, ULA_OP=000, FonteCP=00. EscIR=EscCP=mem_pronto. Stays in BUSCA while mem_pronto=0; -> DECOD when mem_pronto=1.
  - DECOD (2): ULA_A=0, ULA_B=10, ULA_OP=000 (branch target into ULASaida). Next state by opcode:
    - R-type -> EXEC_R.
    - ADDI -> EXEC_I.
    - LW/SW -> END_MEM.
    - BEQ/BNE -> DESVIO.
    - JUMP -> SALTO.
    - NOP -> BUSCA.
    - HALT -> PARADO.
  - EXEC_R (3): ULA_A=1, ULA_B=00, ULA_OP=opcode[2:0] -> ESC_ULA.
  - EXEC_I (4): ULA_A=1, ULA_B=10, ULA_OP=000 -> ESC_ULA.
  - ESC_ULA (5): EscReg=1, MemParaReg=0, RegDst=1 for R-type, 0 for ADDI -> BUSCA.
  - END_MEM (6): ULA_A=1, ULA_B=10, ULA_OP=000. -> LE_MEM for LW, -> ESC_MEM for SW.
  - LE_MEM (7): LeMem=1, IouD=1. Waits on mem_pronto; -> ESC_REG_MEM.
  - ESC_REG_MEM (8): EscReg=1, MemParaReg=1, RegDst=0 -> BUSCA.
  - ESC_MEM (9): EscMem=1, IouD=1. Waits on mem_pronto; -> BUSCA.
  - DESVIO (10): ULA_A=1, ULA_B=00, ULA_OP=001, EscCondCP=1, FonteCP=01, CondInv=(opcode==1101) -> BUSCA.
  - SALTO (11): EscCP=1, FonteCP=10 -> BUSCA.
  - PARADO (12): parado=1, all other outputs 0. Held until rst.
- Latency in cycles, excluding memory wait states:
  - R-type/ADDI: 4.
  - LW: 5.
  - SW: 4.
  - BEQ/BNE: 3.
  - JUMP: 3.
  - NOP: 2.
- Each memory wait cycle adds 1.
- mem_pronto is ignored outside BUSCA, LE_MEM and ESC_MEM.
- Unused state codes 13-15 recover to BUSCA on the next clock with all outputs 0.
- LeMem and EscMem are never asserted together.

Optional Feature:
- Macro CONT_INSTR_EN.
- Defined: port cont_instr exists. It increments by 1, wrapping modulo 2^LARGURA_CONT, on every transition into BUSCA from ESC_ULA, ESC_REG_MEM, ESC_MEM, DESVIO, SALTO or DECOD (NOP). It is not incremented on OCIOSO->BUSCA or on HALT. It resets to 0.
- Undefined: no port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset then opcode=0001, mem_pronto=1 -> estado 0,1,2,3,5,1. In state 3 ULA_OP=001, ULA_A=1, ULA_B=00. In state 5 EscReg=1, RegDst=1.
- LW (1001) with mem_pronto low for 3 cycles in LE_MEM -> LE_MEM held 4 cycles with LeMem=1, IouD=1. Then ESC_REG_MEM asserts EscReg=1, MemParaReg=1. Total 8 cycles fetch-to-fetch.
- BNE (1101) -> DESVIO with EscCondCP=1, CondInv=1, FonteCP=01, ULA_OP=001. BEQ gives CondInv=0.
- JUMP (1011) -> SALTO with EscCP=1, FonteCP=10, EscCondCP=0. Next state BUSCA.
- HALT (1111) -> estado=12, parado=1 held 20 cycles regardless of opcode or mem_pronto. rst pulse -> estado=0, all outputs 0 asynchronously.
- With CONT_INSTR_EN: run ADD, SW, NOP, HALT -> cont_instr=3. Forcing rst mid-LE_MEM -> LeMem=0 before the next clock edge, cont_instr=0.
